// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F00;
  localparam int unsigned SLOT_BYTES   = 16;
  localparam int unsigned SLOT_SHIFT   = $clog2(SLOT_BYTES);

  // Width of a binary slot index; at least one bit even for a single slot.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bridge_decode.sv
// Slot decoder: compares the address tag against each device slot.
module io_bridge_decode
  import io_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV = 3,
  parameter logic [31:0] BASE    = DEFAULT_BASE,
  localparam int unsigned IDX_W  = idx_width(NUM_DEV),
  localparam int unsigned TAG_W  = 32 - SLOT_SHIFT
) (
  input  logic [TAG_W-1:0]   addr_tag,
  output logic [NUM_DEV-1:0] hit,
  output logic               any_hit,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [TAG_W-1:0] BASE_TAG = BASE[31:SLOT_SHIFT];

  // Hit vector and binary index; slots never overlap so at most one hit.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (addr_tag == BASE_TAG + TAG_W'(i)) begin
        hit[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

  assign any_hit = |hit;

endmodule

// File: rtl/io_bridge_mux.sv
// CPU-to-peripheral bridge: slot decode, select/ack handshake with timeout,
// and a registered masked interrupt request.
module io_bridge_mux
  import io_bridge_pkg::*;
#(
  parameter int unsigned          NUM_DEV  = 3,
  parameter logic [31:0]          BASE     = DEFAULT_BASE,
  parameter int unsigned          TIMEOUT  = 15,
  parameter logic [NUM_DEV-1:0]   IRQ_MASK = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [29:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  input  logic [3:0]              cpu_be,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  output logic                    cpu_buserr,
  output logic [1:0]              dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [3:0]              dev_be,
  output logic                    dev_we,
  output logic [NUM_DEV-1:0]      dev_sel,
  input  logic [32*NUM_DEV-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV-1:0]      dev_irq,
  output logic [NUM_DEV-1:0]      hw_int
);

  localparam int unsigned IDX_W = idx_width(NUM_DEV);
  localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [NUM_DEV-1:0] hit;
  logic               any_hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   idx_q;
  logic               req;
  logic               we_q;
  logic               err_q;
  logic [7:0]         timer_q;
  logic               timer_exp;
  logic [31:0]        rdata_q;
  logic [31:0]        sel_rdata;
  logic               ack_sel;

  io_bridge_decode #(
    .NUM_DEV (NUM_DEV),
    .BASE    (BASE)
  ) u_decode (
    .addr_tag (cpu_addr[29:SLOT_SHIFT-2]),
    .hit      (hit),
    .any_hit  (any_hit),
    .idx      (hit_idx)
  );

  assign req       = (cpu_re | cpu_we) & any_hit;
  assign timer_exp = (timer_q == TIMER_LAST);

  // Route the latched slot's read bus and ack line.
  always_comb begin
    sel_rdata = '0;
    ack_sel   = 1'b0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rdata = dev_rdata[32*i +: 32];
        ack_sel   = dev_ack[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    cpu_buserr = 1'b0;
    dev_we     = 1'b0;
    dev_sel    = '0;
    case (state_q)
      IDLE: begin
        cpu_stall = req;
        if (req) state_d = WAIT;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        dev_we    = we_q;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
          dev_sel[i] = (idx_q == IDX_W'(i));
        end
        if (ack_sel || timer_exp) state_d = DONE;
      end
      DONE: begin
        cpu_rdata  = rdata_q;
        cpu_buserr = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access capture at accept, timer, and read/error result in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
      we_q      <= 1'b0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q     <= hit_idx;
            dev_addr  <= cpu_addr[1:0];
            dev_wdata <= cpu_wdata;
            dev_be    <= cpu_be;
            we_q      <= cpu_we;
            timer_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
          end
        end
        WAIT: begin
          if (ack_sel) begin
            rdata_q <= sel_rdata;
            err_q   <= 1'b0;
          end else if (timer_exp) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Interrupt request register, independent of the access FSM.
  always_ff @(posedge clk) begin
    if (reset) hw_int <= '0;
    else       hw_int <= dev_irq & IRQ_MASK;
  end

endmodule

// File: tb/tb_io_bridge_mux.sv
// Self-checking bench for io_bridge_mux (3 slots, TIMEOUT 15, IRQ_MASK 3'b011).
module tb_io_bridge_mux;

  localparam int          NDEV = 3;
  localparam int          TMO  = 15;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_buserr;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic        dev_we;
  logic [2:0]  dev_sel;
  logic [95:0] dev_rdata;
  logic [2:0]  dev_ack;
  logic [2:0]  dev_irq;
  logic [2:0]  hw_int;

  int n_cmp = 0;
  int n_bad = 0;

  io_bridge_mux #(
    .NUM_DEV  (3),
    .BASE     (32'h0000_7F00),
    .TIMEOUT  (15),
    .IRQ_MASK (3'b011)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_be     (cpu_be),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_buserr (cpu_buserr),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_be     (dev_be),
    .dev_we     (dev_we),
    .dev_sel    (dev_sel),
    .dev_rdata  (dev_rdata),
    .dev_ack    (dev_ack),
    .dev_irq    (dev_irq),
    .hw_int     (hw_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One access: byte address, controls, when the slot acks (WAIT cycle
  // number, 0 = never), the slot's read data, and the expected outcome.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_at;
    logic [31:0] dval;
    logic [2:0]  exp_sel;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE through DONE and checks every cycle.
  task automatic run_acc(input vec_t v);
    int slot;
    logic in_wait;
    logic in_done;
    slot = -1;
    for (int i = 0; i < NDEV; i++) if (v.exp_sel[i]) slot = i;
    cpu_addr  = v.addr[31:2];
    cpu_we    = v.we;
    cpu_re    = v.re;
    cpu_wdata = v.wdata;
    cpu_be    = v.be;
    dev_rdata = {$urandom, $urandom, $urandom};
    if (slot >= 0) dev_rdata[slot*32 +: 32] = v.dval;
    for (int c = 0; c <= v.exp_stall; c++) begin
      in_wait = (c >= 1) && (c < v.exp_stall);
      in_done = (v.exp_stall > 0) && (c == v.exp_stall);
      // Unselected slots get noise on their ack lines.
      dev_ack = 3'($urandom) & ~v.exp_sel;
      if (slot >= 0 && v.ack_at != 0 && c == v.ack_at) dev_ack = dev_ack | v.exp_sel;
      @(negedge clk);
      chk("stall", 32'(cpu_stall), 32'(c < v.exp_stall));
      chk("dev_sel", 32'(dev_sel), in_wait ? 32'(v.exp_sel) : 32'd0);
      chk("dev_we", 32'(dev_we), in_wait ? 32'(v.we) : 32'd0);
      chk("cpu_rdata", cpu_rdata, in_done ? v.exp_rdata : 32'd0);
      chk("buserr", 32'(cpu_buserr), in_done ? 32'(v.exp_err) : 32'd0);
      if (in_wait) begin
        chk("dev_addr", 32'(dev_addr), 32'(v.addr[3:2]));
        chk("dev_wdata", dev_wdata, v.wdata);
        chk("dev_be", 32'(dev_be), 32'(v.be));
      end
      next_cycle();
    end
    dev_ack = '0;
    cpu_we  = 1'b0;
    cpu_re  = 1'b0;
  endtask

  // Reference model: derives the outcome from address arithmetic and the
  // ack/timeout rules.
  function automatic vec_t make_rand();
    vec_t v;
    int kind;
    int op;
    int s;
    logic hit;
    logic acked;
    kind = $urandom_range(0, 4);
    case (kind)
      0, 1, 2: v.addr = BASE + 32'($urandom_range(0, NDEV - 1) * 16) + 32'($urandom_range(0, 3) * 4);
      3:       v.addr = BASE + 32'(NDEV * 16) + 32'($urandom_range(0, 3) * 4);
      default: v.addr = $urandom & 32'hFFFF_FFFC;
    endcase
    op        = $urandom_range(0, 2);
    v.re      = (op != 1);
    v.we      = (op != 0);
    v.wdata   = $urandom;
    v.be      = 4'($urandom);
    v.ack_at  = $urandom_range(0, TMO + 3);
    v.dval    = v.we ? 32'd0 : $urandom;
    hit       = (v.addr >= BASE) && (v.addr < BASE + 32'(NDEV * 16));
    s         = hit ? int'((v.addr - BASE) / 16) : 0;
    acked     = (v.ack_at >= 1) && (v.ack_at <= TMO);
    v.exp_sel   = hit ? 3'(1 << s) : 3'd0;
    v.exp_stall = !hit ? 0 : (acked ? v.ack_at + 1 : TMO + 1);
    v.exp_rdata = (hit && acked) ? v.dval : 32'd0;
    v.exp_err   = hit && !acked;
    return v;
  endfunction

  initial begin
    vec_t v;
    //          addr          we  re  wdata          be     ack dval           sel     stl rdata          err
    tbl[0] = '{32'h0000_7F04, 1, 0, 32'hA5A5_0001, 4'hF,  1, 32'h0000_0000, 3'b001,  2, 32'h0000_0000, 0};
    tbl[1] = '{32'h0000_7F10, 0, 1, 32'h0000_0000, 4'hF,  3, 32'h1234_5678, 3'b010,  4, 32'h1234_5678, 0};
    tbl[2] = '{32'h0000_7F20, 0, 1, 32'h0000_0000, 4'hF,  0, 32'h7777_7777, 3'b100, 16, 32'h0000_0000, 1};
    tbl[3] = '{32'h0000_7F30, 0, 1, 32'h0000_0000, 4'hF,  1, 32'h0000_0000, 3'b000,  0, 32'h0000_0000, 0};
    tbl[4] = '{32'h0000_1000, 1, 0, 32'hFFFF_FFFF, 4'hF,  1, 32'h0000_0000, 3'b000,  0, 32'h0000_0000, 0};
    tbl[5] = '{32'h0000_7F2C, 0, 1, 32'h0000_0000, 4'hF, 15, 32'hCAFE_F00D, 3'b100, 16, 32'hCAFE_F00D, 0};
    tbl[6] = '{32'h0000_7EFC, 0, 1, 32'h0000_0000, 4'hF,  1, 32'h0000_0000, 3'b000,  0, 32'h0000_0000, 0};
    tbl[7] = '{32'h0000_7F18, 1, 1, 32'h0BAD_BEEF, 4'hC,  1, 32'h0000_0000, 3'b010,  2, 32'h0000_0000, 0};
    tbl[8] = '{32'h0000_7F08, 1, 0, 32'h5A5A_3C3C, 4'h3,  2, 32'h0000_0000, 3'b001,  3, 32'h0000_0000, 0};

    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_be    = '0;
    dev_rdata = '0;
    dev_ack   = '0;
    dev_irq   = '0;
    next_cycle();
    next_cycle();

    // Reset state.
    @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_sel", 32'(dev_sel), 32'd0);
    chk("rst_we", 32'(dev_we), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_buserr", 32'(cpu_buserr), 32'd0);
    chk("rst_dev_addr", 32'(dev_addr), 32'd0);
    chk("rst_dev_wdata", dev_wdata, 32'd0);
    chk("rst_dev_be", 32'(dev_be), 32'd0);
    chk("rst_hw_int", 32'(hw_int), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < 9; i++) run_acc(tbl[i]);

    // Randomized accesses with idle gaps.
    for (int n = 0; n < 80; n++) begin
      v = make_rand();
      run_acc(v);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_sel", 32'(dev_sel), 32'd0);
        chk("idle_rdata", cpu_rdata, 32'd0);
        next_cycle();
      end
    end

    // Reset during the second WAIT cycle of a load.
    cpu_addr  = 30'(32'h0000_7F10 >> 2);
    cpu_re    = 1'b1;
    cpu_wdata = 32'h1111_2222;
    cpu_be    = 4'h6;
    dev_rdata = {32'h0, 32'h55AA_55AA, 32'h0};
    dev_ack   = '0;
    dev_irq   = 3'b111;
    @(negedge clk);
    chk("mr_idle_stall", 32'(cpu_stall), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("mr_wait1_sel", 32'(dev_sel), 32'b010);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_wait2_sel", 32'(dev_sel), 32'b010);
    next_cycle();
    reset  = 1'b0;
    cpu_re = 1'b0;
    @(negedge clk);
    chk("mr_sel", 32'(dev_sel), 32'd0);
    chk("mr_stall", 32'(cpu_stall), 32'd0);
    chk("mr_we", 32'(dev_we), 32'd0);
    chk("mr_dev_wdata", dev_wdata, 32'd0);
    chk("mr_dev_be", 32'(dev_be), 32'd0);
    chk("mr_hw_int", 32'(hw_int), 32'd0);
    next_cycle();
    dev_ack = 3'b010;
    @(negedge clk);
    chk("late_ack_sel", 32'(dev_sel), 32'd0);
    chk("late_ack_stall", 32'(cpu_stall), 32'd0);
    chk("late_ack_hw_int", 32'(hw_int), 32'b011);
    next_cycle();
    dev_ack = '0;
    dev_irq = '0;
    @(negedge clk);
    chk("late_ack_rdata", cpu_rdata, 32'd0);
    chk("late_ack_buserr", 32'(cpu_buserr), 32'd0);
    chk("late_ack_sel2", 32'(dev_sel), 32'd0);
    next_cycle();
    run_acc(tbl[1]);

    // Interrupt masking and one-cycle latency.
    dev_irq = 3'b101;
    @(negedge clk);
    chk("irq_before", 32'(hw_int), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("irq_masked", 32'(hw_int), 32'b001);
    dev_irq = 3'b000;
    next_cycle();
    @(negedge clk);
    chk("irq_drop", 32'(hw_int), 32'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bridge_mux.md
Name: io_bridge_mux

Overview:
Parametrised CPU-to-peripheral bridge for the pipelined MIPS core. It replaces the fixed three-device decoder with NUM_DEV equally spaced 16-byte device slots. Each access uses a registered select/ack handshake, so the pipeline is stalled until the device answers or a timeout fires. It also collects the device interrupt lines into a registered, masked request for the CP0 HWInt inputs.

Parameters:
NUM_DEV, 3, number of device slots (1..8).
BASE, 32'h0000_7F00, byte address of slot 0; slot i spans BASE+16*i .. BASE+16*i+15.
TIMEOUT, 15, maximum WAIT cycles before a bus error (1..255).
IRQ_MASK, {NUM_DEV{1'b1}}, static per-device interrupt enable.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
cpu_addr  in  30  word address [31:2] from the MEM stage.
cpu_wdata  in  32  store data.
cpu_we  in  1  store request.
cpu_re  in  1  load request.
cpu_be  in  4  byte enables.
cpu_rdata  out  32  load data; valid in the DONE cycle.
cpu_stall  out  1  freezes the pipeline while a device access is in flight.
cpu_buserr  out  1  one-cycle pulse with DONE when the access timed out.
dev_addr  out  2  cpu_addr[3:2], registered at accept.
dev_wdata  out  32  cpu_wdata, registered at accept.
dev_be  out  4  cpu_be, registered at accept.
dev_we  out  1  write strobe, high with dev_sel during WAIT for stores.
dev_sel  out  NUM_DEV  one-hot select, high during WAIT only.
dev_rdata  in  32*NUM_DEV  flat read buses; slot i occupies bits [32i+31:32i].
dev_ack  in  NUM_DEV  device done; sampled only for the selected slot.
dev_irq  in  NUM_DEV  level interrupt requests.
hw_int  out  NUM_DEV  registered dev_irq & IRQ_MASK.

Behaviour:
- Decode (combinational):
  - hit[i] = (cpu_addr[31:4] == BASE[31:4] + i).
  - req = (cpu_re | cpu_we) & |hit.
  - cpu_re and cpu_we never arrive together; if both are high, treat the access as a store.
- Miss (request with no hit):
  - Stores are dropped; loads return 32'd0.
  - No stall and no buserr.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when req is high, latch slot index, dev_addr, dev_wdata, dev_be and dev_we (= cpu_we), clear the timer, and go to WAIT.
  - WAIT:
    - dev_sel[idx] = 1.
    - If dev_ack[idx] = 1: capture dev_rdata slot idx into the read register and go to DONE.
    - Otherwise, if timer == TIMEOUT-1: set the error flag, read register = 0, go to DONE.
    - Otherwise increment the timer.
    - Ack takes priority over timeout in the same cycle.
  - DONE: cpu_rdata = read register, cpu_buserr = error flag, then go to IDLE unconditionally.
- cpu_stall = (state==IDLE & req) | (state==WAIT). It is low in DONE, so the CPU retires the access there.
- The CPU holds its address and controls stable while stalled. The bridge never re-samples them after accept.
- Latency:
  - Ack in the first WAIT cycle gives stall high for 2 cycles and data in cycle 3.
  - Timeout gives TIMEOUT WAIT cycles.
- Back-to-back: a new request in the cycle after DONE is accepted from IDLE normally. There is no request issued in DONE.
- dev_we is held for the whole WAIT. Devices write once, on their ack cycle.
- hw_int: registered every cycle (one-cycle latency), independent of the FSM.
- Reset (also mid-access): state=IDLE, dev_sel=0, dev_we=0, cpu_stall=0 once registered state clears, cpu_buserr=0, cpu_rdata=0, dev_addr/dev_wdata/dev_be=0, hw_int=0, timer=0. A pending access is abandoned and not completed.
- Outside DONE, cpu_rdata = 0, except on a load miss, where it is also 0.

Decomposition:
- Shared package io_bridge_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), default BASE, and the slot size constant 16.
- One natural sub-module, io_bridge_decode: combinational hit vector plus binary slot index, parametrised on NUM_DEV and BASE.
- Timer, FSM and irq register stay in the top module.

Test Plan:
- Store to 0x7F04 (slot 0), data 0xA5A5_0001, be=4'hF; slot 0 acks in its first WAIT cycle -> dev_sel=3'b001 and dev_we=1 for 1 cycle, dev_addr=2'b01, stall high 2 cycles, buserr=0.
- Load from 0x7F10 (slot 1); ack after 3 WAIT cycles with dev_rdata slot1 = 0x1234_5678 -> stall high 4 cycles, cpu_rdata = 0x1234_5678 in DONE.
- Load from 0x7F20 (slot 2), ack never asserted, TIMEOUT=15 -> 15 WAIT cycles, then a DONE cycle with buserr=1 and cpu_rdata=0; next cycle IDLE.
- Load from 0x7F30 and store to 0x0000_1000 (misses) -> no stall, cpu_rdata=0, dev_sel stays 0.
- Reset asserted during the 2nd WAIT cycle of a load -> next edge: dev_sel=0, stall=0, state IDLE; a later ack is ignored.
- dev_irq=3'b101 with IRQ_MASK=3'b011 -> hw_int=3'b001 one cycle later; dev_irq drops -> hw_int=0 one cycle later.
